// File: rtl/ritc_align_sequencer.sv
// Per-bit alignment controller for the dual-RITC datapath: sweeps DPIDELAY over all taps,
// centres the widest stable eye, then bitslips until the training readback matches.
module ritc_align_sequencer #(
  parameter int SETTLE   = 64,
  parameter int MIN_EYE  = 4,
  parameter int MAX_SLIP = 8
) (
  input  logic        user_clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [7:0]  pattern_i,
  input  logic [5:0]  ch_mask_i,
  output logic        dp_sel_o,
  output logic        dp_wr_o,
  output logic [3:0]  dp_addr_o,
  output logic [31:0] dp_dat_o,
  input  logic [31:0] dp_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [6:0]  fail_count_o,
  output logic [6:0]  last_fail_o,
  output logic [6:0]  cur_sel_o,
  output logic [4:0]  cur_delay_o
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int SW = $clog2(MAX_SLIP + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [SW-1:0] SLIP_LAST   = SW'(MAX_SLIP);
  localparam logic [5:0]    MIN_EYE_W   = 6'(MIN_EYE);
  localparam logic [3:0]    DP_TRAIN    = 4'd2;
  localparam logic [3:0]    DP_IDELAY   = 4'd4;
  localparam logic [1:0]    F_NONE      = 2'b00;
  localparam logic [1:0]    F_SLIP      = 2'b01;
  localparam logic [1:0]    F_LOAD      = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_DLOAD, S_WAIT_A, S_READ_A, S_WAIT_B, S_READ_B,
    S_EVAL, S_CENTER, S_WAIT_S, S_READ_S, S_SLIP, S_NEXT, S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   slips;
  logic [7:0]      pattern;
  logic [5:0]      mask;
  logic [7:0]      cap_a;
  logic [7:0]      cap_b;
  logic [5:0]      run_len;
  logic [4:0]      run_start;
  logic [5:0]      best_len;
  logic [4:0]      best_start;

  logic            tap_good;
  logic [5:0]      nrun_len;
  logic [4:0]      nrun_start;
  logic [5:0]      nbest_len;
  logic [4:0]      nbest_start;
  logic [4:0]      centre;
  logic [2:0]      first_ch;
  logic [2:0]      nxt_ch;
  logic [6:0]      sel_inc;
  logic            unused_hi;

  assign unused_hi = ^dp_dat_i[31:8];

  // Lowest enabled channel at or above 'from'; 6 means none left.
  function automatic logic [2:0] next_ch(input logic [5:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd6;
    for (int i = 5; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [31:0] dp_word(input logic [1:0] flags, input logic [6:0] s,
                                          input logic [4:0] d);
    return {flags, 7'd0, s, 11'd0, d};
  endfunction

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v == 7'd127) ? 7'd127 : v + 7'd1;
  endfunction

  always_comb begin
    tap_good    = (cap_a == cap_b) && (cap_a != 8'h00) && (cap_a != 8'hFF);
    nrun_len    = 6'd0;
    nrun_start  = run_start;
    nbest_len   = best_len;
    nbest_start = best_start;
    if (tap_good) begin
      nrun_len = run_len + 6'd1;
      if (run_len == 6'd0) nrun_start = cur_delay_o;
      // strictly greater: the first of equally wide runs is kept
      if (nrun_len > best_len) begin
        nbest_len   = nrun_len;
        nbest_start = nrun_start;
      end
    end
    centre   = nbest_start + 5'((nbest_len - 6'd1) >> 1);
    first_ch = next_ch(ch_mask_i, 3'd0);
    nxt_ch   = next_ch(mask, cur_sel_o[6:4] + 3'd1);
    sel_inc  = cur_sel_o + 7'd1;
  end

  always_ff @(posedge user_clk_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      slips        <= '0;
      run_len      <= '0;
      run_start    <= '0;
      best_len     <= '0;
      best_start   <= '0;
      dp_sel_o     <= 1'b0;
      dp_wr_o      <= 1'b0;
      dp_addr_o    <= '0;
      dp_dat_o     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      fail_count_o <= '0;
      last_fail_o  <= '0;
      cur_sel_o    <= '0;
      cur_delay_o  <= '0;
    end else begin
      dp_sel_o  <= 1'b0;
      dp_wr_o   <= 1'b0;
      dp_addr_o <= '0;
      dp_dat_o  <= '0;
      done_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            pattern      <= pattern_i;
            mask         <= ch_mask_i;
            fail_count_o <= '0;
            last_fail_o  <= '0;
            busy_o       <= 1'b1;
            if (ch_mask_i == 6'd0) begin
              state <= S_DONE;
            end else begin
              cur_sel_o <= {first_ch, 4'd0};
              dp_sel_o  <= 1'b1;
              dp_wr_o   <= 1'b1;
              dp_addr_o <= DP_TRAIN;
              dp_dat_o  <= dp_word(F_NONE, {first_ch, 4'd0}, 5'd0);
              state     <= S_SEL;
            end
          end
        end
        S_SEL: begin
          run_len     <= '0;
          run_start   <= '0;
          best_len    <= '0;
          best_start  <= '0;
          cur_delay_o <= 5'd0;
          dp_sel_o    <= 1'b1;
          dp_wr_o     <= 1'b1;
          dp_addr_o   <= DP_IDELAY;
          dp_dat_o    <= dp_word(F_LOAD, cur_sel_o, 5'd0);
          state       <= S_DLOAD;
        end
        S_DLOAD: begin
          cnt   <= '0;
          state <= S_WAIT_A;
        end
        S_WAIT_A, S_WAIT_B, S_WAIT_S: begin
          if (cnt == SETTLE_LAST) begin
            dp_sel_o  <= 1'b1;
            dp_addr_o <= DP_TRAIN;
            state     <= (state == S_WAIT_A) ? S_READ_A :
                         (state == S_WAIT_B) ? S_READ_B : S_READ_S;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READ_A: begin
          cap_a <= dp_dat_i[7:0];
          cnt   <= '0;
          state <= S_WAIT_B;
        end
        S_READ_B: begin
          cap_b <= dp_dat_i[7:0];
          state <= S_EVAL;
        end
        S_EVAL: begin
          run_len    <= nrun_len;
          run_start  <= nrun_start;
          best_len   <= nbest_len;
          best_start <= nbest_start;
          dp_sel_o   <= 1'b1;
          dp_wr_o    <= 1'b1;
          dp_addr_o  <= DP_IDELAY;
          if (cur_delay_o == 5'd31) begin
            // last tap swept: this write loads the eye centre, or tap 0 for a closed eye
            state <= S_CENTER;
            if (nbest_len < MIN_EYE_W) begin
              cur_delay_o <= 5'd0;
              dp_dat_o    <= dp_word(F_LOAD, cur_sel_o, 5'd0);
            end else begin
              cur_delay_o <= centre;
              dp_dat_o    <= dp_word(F_LOAD, cur_sel_o, centre);
            end
          end else begin
            cur_delay_o <= cur_delay_o + 5'd1;
            dp_dat_o    <= dp_word(F_LOAD, cur_sel_o, cur_delay_o + 5'd1);
            state       <= S_DLOAD;
          end
        end
        S_CENTER: begin
          slips <= '0;
          cnt   <= '0;
          if (best_len < MIN_EYE_W) begin
            fail_count_o <= sat_inc(fail_count_o);
            last_fail_o  <= cur_sel_o;
            state        <= S_NEXT;
          end else begin
            state <= S_WAIT_S;
          end
        end
        S_READ_S: begin
          if (dp_dat_i[7:0] == pattern) begin
            state <= S_NEXT;
          end else if (slips == SLIP_LAST) begin
            fail_count_o <= sat_inc(fail_count_o);
            last_fail_o  <= cur_sel_o;
            state        <= S_NEXT;
          end else begin
            dp_sel_o  <= 1'b1;
            dp_wr_o   <= 1'b1;
            dp_addr_o <= DP_TRAIN;
            dp_dat_o  <= dp_word(F_SLIP, cur_sel_o, 5'd0);
            state     <= S_SLIP;
          end
        end
        S_SLIP: begin
          slips <= slips + 1'b1;
          cnt   <= '0;
          state <= S_WAIT_S;
        end
        S_NEXT: begin
          if (cur_sel_o[3:0] != 4'd11) begin
            cur_sel_o <= sel_inc;
            dp_sel_o  <= 1'b1;
            dp_wr_o   <= 1'b1;
            dp_addr_o <= DP_TRAIN;
            dp_dat_o  <= dp_word(F_NONE, sel_inc, 5'd0);
            state     <= S_SEL;
          end else if (nxt_ch == 3'd6) begin
            state <= S_DONE;
          end else begin
            cur_sel_o <= {nxt_ch, 4'd0};
            dp_sel_o  <= 1'b1;
            dp_wr_o   <= 1'b1;
            dp_addr_o <= DP_TRAIN;
            dp_dat_o  <= dp_word(F_NONE, {nxt_ch, 4'd0}, 5'd0);
            state     <= S_SEL;
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ritc_align_sequencer.sv
// Bench for ritc_align_sequencer: behavioural datapath model, per-bit scoreboard of the
// final IDELAY load and slip count, plus directed reset/start/mask checks.
module tb_ritc_align_sequencer;

  localparam int SETTLE   = 3;
  localparam int MIN_EYE  = 4;
  localparam int MAX_SLIP = 8;
  localparam int BUDGET   = 40000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pattern_in = 8'h00;
  logic [5:0]  mask_in = 6'h00;
  logic        dp_sel, dp_wr;
  logic [3:0]  dp_addr;
  logic [31:0] dp_dat_o, dp_dat_i;
  logic        busy, done;
  logic [6:0]  fail_count, last_fail, cur_sel;
  logic [4:0]  cur_delay;

  always #5 clk = ~clk;

  ritc_align_sequencer #(.SETTLE(SETTLE), .MIN_EYE(MIN_EYE), .MAX_SLIP(MAX_SLIP)) dut (
    .user_clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pattern_i(pattern_in),
    .ch_mask_i(mask_in), .dp_sel_o(dp_sel), .dp_wr_o(dp_wr), .dp_addr_o(dp_addr),
    .dp_dat_o(dp_dat_o), .dp_dat_i(dp_dat_i), .busy_o(busy), .done_o(done),
    .fail_count_o(fail_count), .last_fail_o(last_fail), .cur_sel_o(cur_sel),
    .cur_delay_o(cur_delay)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, req);
    end
  endtask

  // Datapath model: mode selects the eye map; the good-tap byte becomes the pattern
  // only after enough slips on the current bit.
  int         mode = 1;
  logic [7:0] m_pat = 8'hA5;
  logic [6:0] m_sel = 7'd0;
  logic [4:0] m_delay = 5'd0;
  int         m_slips = 0;
  logic       m_tog = 1'b0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (dp_sel && dp_wr && dp_addr == 4'd2) begin
      m_sel <= dp_dat_o[22:16];
      m_slips <= dp_dat_o[30] ? m_slips + 1 : 0;
    end
    if (dp_sel && dp_wr && dp_addr == 4'd4) m_delay <= dp_dat_o[4:0];
    if (dp_sel && !dp_wr) m_tog <= ~m_tog;
  end

  function automatic bit tap_ok(input int md, input logic [6:0] s, input int d);
    if (md == 2 && s == 7'h00) return (d >= 2 && d <= 6) || (d >= 20 && d <= 24);
    if (md == 2 && s == 7'h01) return d >= 26;
    if (md == 2 && s == 7'h02) return 1'b1;
    if (md == 3 && s == 7'h27) return d >= 10 && d <= 12;
    return d >= 10 && d <= 19;
  endfunction

  function automatic int need_slips(input int md, input logic [6:0] s);
    return (md == 4 && s == 7'h5B) ? 1000 : 3;
  endfunction

  always_comb begin
    logic [7:0] rd;
    rd = 8'h00;
    if (tap_ok(mode, m_sel, int'(m_delay)))
      rd = (m_slips >= need_slips(mode, m_sel)) ? m_pat : 8'h5A;
    else if (int'(m_delay) % 3 == 0) rd = 8'h00;
    else if (int'(m_delay) % 3 == 1) rd = 8'hFF;
    else rd = m_tog ? 8'h3C : 8'h3D;
    dp_dat_i = {24'hC0FFEE, rd};
  end

  typedef struct packed { logic [6:0] sel; logic [4:0] delay; logic [3:0] slips; } bit_exp_t;
  typedef struct packed { logic [6:0] fc; logic [6:0] lf; } done_exp_t;
  bit_exp_t  exp_q[$];
  done_exp_t done_q[$];
  int        n_done = 0;
  int        idle_err = 0;

  bit         act = 1'b0;
  logic [6:0] b_sel;
  int         b_delay, b_slips, b_nd, b_fmt, last_wr;

  task automatic finalize();
    bit_exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_bit: got sel 'h%0h, expected none", b_sel);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("sel_%0h", e.sel), b_sel, e.sel);
      check($sformatf("final_delay_%0h", e.sel), b_delay, e.delay);
      check($sformatf("slips_%0h", e.sel), b_slips, e.slips);
      check($sformatf("idelay_writes_%0h", e.sel), b_nd, 33);
      check($sformatf("bus_format_%0h", e.sel), b_fmt, 0);
    end
  endtask

  // Monitor: follows bus writes per bit and done_o, pops expectations as they occur.
  initial forever begin
    done_exp_t d;
    @(negedge clk);
    if (!rst_n) begin
      act = 1'b0;
    end else begin
      if (!dp_sel && (dp_wr || dp_addr != 4'd0 || dp_dat_o != 32'd0)) idle_err++;
      if (dp_sel && !dp_wr && dp_addr != 4'd2) b_fmt++;
      if (dp_sel && dp_wr) begin
        if (dp_addr == 4'd2 && !dp_dat_o[30]) begin
          if (act) finalize();
          act = 1'b1; b_sel = dp_dat_o[22:16];
          b_delay = -1; b_slips = 0; b_nd = 0; b_fmt = 0;
          if (dp_dat_o[31:23] != 9'd0 || dp_dat_o[15:0] != 16'd0) b_fmt++;
        end else if (!act) begin
          idle_err++;
        end else if (dp_addr == 4'd2) begin
          b_slips++;
          if (dp_dat_o[31] || dp_dat_o[29:23] != 7'd0 || dp_dat_o[22:16] != b_sel ||
              dp_dat_o[15:0] != 16'd0) b_fmt++;
          if (cyc - last_wr != SETTLE + 2) b_fmt++;
        end else if (dp_addr == 4'd4) begin
          if (!dp_dat_o[31] || dp_dat_o[30:23] != 8'd0 || dp_dat_o[22:16] != b_sel ||
              dp_dat_o[15:5] != 11'd0) b_fmt++;
          if (b_nd < 32 && int'(dp_dat_o[4:0]) != b_nd) b_fmt++;
          if (cyc - last_wr != ((b_nd == 0) ? 1 : 2 * SETTLE + 4)) b_fmt++;
          b_nd++;
          b_delay = int'(dp_dat_o[4:0]);
        end else begin
          b_fmt++;
        end
        last_wr = cyc;
      end
      if (done) begin
        n_done++;
        if (act) finalize();
        act = 1'b0;
        check("bits_left_at_done", exp_q.size(), 0);
        check("bus_idle_clean", idle_err, 0);
        check("busy_at_done", busy, 0);
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done_o=1, expected 0");
        end else begin
          d = done_q.pop_front();
          check("fail_count", fail_count, d.fc);
          check("last_fail", last_fail, d.lf);
        end
      end
    end
  end

  task automatic push_bits(input int md, input logic [5:0] m);
    bit_exp_t e;
    for (int ch = 0; ch < 6; ch++) begin
      if (m[ch]) begin
        for (int b = 0; b < 12; b++) begin
          e.sel = {3'(ch), 4'(b)}; e.delay = 5'd14; e.slips = 4'd3;
          if (md == 2 && e.sel == 7'h00) e.delay = 5'd4;
          if (md == 2 && e.sel == 7'h01) e.delay = 5'd28;
          if (md == 2 && e.sel == 7'h02) e.delay = 5'd15;
          if (md == 3 && e.sel == 7'h27) begin e.delay = 5'd0; e.slips = 4'd0; end
          if (md == 4 && e.sel == 7'h5B) e.slips = 4'd8;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic push_done(input logic [6:0] fc, input logic [6:0] lf);
    done_exp_t d;
    d.fc = fc; d.lf = lf;
    done_q.push_back(d);
  endtask

  task automatic pulse_start(input logic [7:0] p, input logic [5:0] m);
    @(negedge clk);
    pattern_in = p; mask_in = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done_o in %0d cycles, expected done_o=1", nm, BUDGET);
      exp_q.delete(); done_q.delete();
    end
    @(negedge clk);
    check({nm, "_done_width"}, done, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail_count"}, fail_count, 0);
    check({tag, "_last_fail"}, last_fail, 0);
    check({tag, "_cur_sel"}, cur_sel, 0);
    check({tag, "_cur_delay"}, cur_delay, 0);
    check({tag, "_bus"}, int'({dp_sel, dp_wr, dp_addr}) | int'(dp_dat_o), 0);
  endtask

  initial begin
    // reset, with start_i held high underneath it
    rst_n = 1'b0; start = 1'b1; mask_in = 6'h01;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("start_under_reset_busy", busy, 0);

    // single eye 10..19, 3 slips per bit; a second start mid-run must be ignored
    mode = 1;
    push_bits(1, 6'h01); push_done(7'd0, 7'd0);
    pulse_start(8'hA5, 6'h01);
    check("busy_rise", busy, 1);
    repeat (200) @(negedge clk);
    pulse_start(8'h00, 6'h3F);
    wait_done("eye10");
    check("done_pulses_1", n_done, 1);

    // two equal eyes, eye at top taps, fully open
    mode = 2;
    push_bits(2, 6'h01); push_done(7'd0, 7'd0);
    pulse_start(8'hA5, 6'h01);
    wait_done("shapes");
    check("done_pulses_2", n_done, 2);

    // narrow eye on ch2 bit7, all channels
    mode = 3;
    push_bits(3, 6'h3F); push_done(7'd1, 7'h27);
    pulse_start(8'hA5, 6'h3F);
    wait_done("narrow");
    check("done_pulses_3", n_done, 3);

    // pattern never found on ch5 bit11
    mode = 4;
    push_bits(4, 6'h20); push_done(7'd1, 7'h5B);
    pulse_start(8'hA5, 6'h20);
    wait_done("noslip");
    check("done_pulses_4", n_done, 4);

    // one-cycle reset mid-sweep, then a clean restart
    mode = 1;
    pulse_start(8'hA5, 6'h01);
    repeat (100) @(negedge clk);
    check("midsweep_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    #1 rst_n = 1'b1;
    push_bits(1, 6'h01); push_done(7'd0, 7'd0);
    pulse_start(8'hA5, 6'h01);
    wait_done("restart");
    check("done_pulses_5", n_done, 5);

    // all channels masked: busy one cycle, then done, no bus activity
    push_done(7'd0, 7'd0);
    pulse_start(8'hA5, 6'h00);
    check("mask0_busy", busy, 1);
    check("mask0_nodone", done, 0);
    check("mask0_bus", dp_sel, 0);
    @(negedge clk);
    check("mask0_busy_fall", busy, 0);
    check("mask0_done", done, 1);
    check("mask0_bus2", dp_sel, 0);
    @(negedge clk);
    check("mask0_done_width", done, 0);
    check("done_pulses_6", n_done, 6);
    check("done_queue_empty", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
